// File: rtl/mod_carga_matriz_5x5_pkg.sv
// Shared definitions for the 5x5 matrix loader: FSM states, widths, error codes.
// Optional build macro used by the top: DET_TIMEOUT_EN.
package mod_carga_matriz_5x5_pkg;

    localparam int N_ELEM  = 25;
    localparam int DW      = 8;
    localparam int RW      = 16;
    localparam int TIMEOUT = 64;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_EARLY_LAST = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

    localparam logic [RW-1:0] RES_ABORT = 16'h8000;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/mod_carga_matriz_5x5_buffer.sv
// 25-entry element register file for the matrix loader; one write port, flat read bus.
// Element k lives at mat_flat[k*DW +: DW].
module mod_buffer_matriz
    import mod_carga_matriz_5x5_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [DW-1:0]        data,
    output logic [N_ELEM*DW-1:0] mat_flat
);

    for (genvar k = 0; k < N_ELEM; k++) begin : g_elem
        always_ff @(posedge clk) begin
            if (rst) begin
                mat_flat[k*DW +: DW] <= '0;
            end else if (we && (idx == IDX_W'(k))) begin
                mat_flat[k*DW +: DW] <= data;
            end
        end
    end

endmodule

// File: rtl/mod_carga_matriz_5x5.sv
// Serial loader/sequencer feeding mod_det_5x5: collects 25 elements, starts the
// determinant, captures the result on a fresh done edge and hands it to the host.
// Build option: define DET_TIMEOUT_EN to abort a WAIT that sees no done edge.
module mod_carga_matriz_5x5
    import mod_carga_matriz_5x5_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic [N_ELEM*DW-1:0] mat_flat,
    output logic                 det_start,
    input  logic                 det_done,
    input  logic [RW-1:0]        det_resultado,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RW-1:0]        res_data,
    output logic                 busy,
    output logic                 err_pulse,
    output logic [1:0]           err_code
);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [RW-1:0]    res_data_next;
    logic [1:0]       err_code_next;
    logic             err_set;
    logic             done_q;
    logic             done_edge;
    logic             beat;
    logic             buf_we;

`ifdef DET_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
`endif

    assign in_ready  = (state == ST_LOAD);
    assign det_start = (state == ST_START);
    assign res_valid = (state == ST_OUT);
    assign busy      = (state != ST_LOAD);
    assign beat      = in_valid && in_ready;
    // Only a 0->1 transition counts, so a done level left over from before is never taken.
    assign done_edge = det_done && !done_q;

    mod_buffer_matriz u_buffer (
        .clk      (clk),
        .rst      (rst),
        .we       (buf_we),
        .idx      (idx),
        .data     (in_data),
        .mat_flat (mat_flat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            idx       <= '0;
            res_data  <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            res_data  <= res_data_next;
            err_pulse <= err_set;
            err_code  <= err_code_next;
            done_q    <= det_done;
        end
    end

`ifdef DET_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end
`endif

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        res_data_next = res_data;
        err_code_next = err_code;
        err_set       = 1'b0;
        buf_we        = 1'b0;
`ifdef DET_TIMEOUT_EN
        wait_cnt_next = wait_cnt;
`endif
        case (state)
            ST_LOAD: begin
                if (beat) begin
                    if (idx == LAST_IDX) begin
                        buf_we     = 1'b1;
                        idx_next   = '0;
                        state_next = ST_START;
                    end else if (in_last) begin
                        idx_next      = '0;
                        err_set       = 1'b1;
                        err_code_next = ERR_EARLY_LAST;
                    end else begin
                        buf_we   = 1'b1;
                        idx_next = idx + 1'b1;
                    end
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
`ifdef DET_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            ST_WAIT: begin
                if (done_edge) begin
                    res_data_next = det_resultado;
                    state_next    = ST_OUT;
`ifdef DET_TIMEOUT_EN
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    res_data_next = RES_ABORT;
                    err_set       = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                    state_next    = ST_OUT;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
`endif
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_carga_matriz_5x5.sv
// Directed bench for mod_carga_matriz_5x5 with a stub standing in for mod_det_5x5.
// Honours DET_TIMEOUT_EN the same way the design does.
module tb_mod_carga_matriz_5x5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic [199:0] mat_flat;
    logic         det_start;
    logic         det_done;
    logic [15:0]  det_resultado;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_data;
    logic         busy;
    logic         err_pulse;
    logic [1:0]   err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [25];

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       exp_ready;
        logic       exp_start;
    } vec_t;

    vec_t vecs [26];

    mod_carga_matriz_5x5 dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .mat_flat      (mat_flat),
        .det_start     (det_start),
        .det_done      (det_done),
        .det_resultado (det_resultado),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [199:0] act, input logic [199:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [199:0] model_flat();
        logic [199:0] f;
        f = '0;
        for (int k = 0; k < 25; k++) f[k*8 +: 8] = mdl[k];
        return f;
    endfunction

    task automatic check_reset(input string tag);
        check_output({tag, " in_ready"},  200'(in_ready),  200'(1'b1));
        check_output({tag, " det_start"}, 200'(det_start), 200'(1'b0));
        check_output({tag, " res_valid"}, 200'(res_valid), 200'(1'b0));
        check_output({tag, " res_data"},  200'(res_data),  200'(16'h0000));
        check_output({tag, " busy"},      200'(busy),      200'(1'b0));
        check_output({tag, " err_pulse"}, 200'(err_pulse), 200'(1'b0));
        check_output({tag, " err_code"},  200'(err_code),  200'(2'b00));
        check_output({tag, " mat_flat"},  mat_flat,        200'(0));
        for (int k = 0; k < 25; k++) mdl[k] = 8'h00;
    endtask

    // Full frame of base+k, in_last on the 25th beat; det_start must appear only after it.
    task automatic send_frame(input logic [7:0] base);
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(k);
            in_last  = (k == 24);
            tick();
            mdl[k] = base + 8'(k);
            check_output("frame det_start", 200'(det_start), 200'(k == 24));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_output("frame mat_flat", mat_flat, model_flat());
    endtask

    task automatic apply_stimulus(input vec_t v);
        in_valid = v.valid;
        in_data  = v.data;
        in_last  = v.last;
        tick();
    endtask

    initial begin
        automatic logic [7:0] tmat [25] = '{
            8'd1, 8'd2, 8'd2, 8'd2, 8'd1,
            8'd2, 8'd1, 8'd2, 8'd2, 8'd1,
            8'd1, 8'd2, 8'd3, 8'd1, 8'd2,
            8'd2, 8'd2, 8'd1, 8'd2, 8'd1,
            8'd2, 8'd1, 8'd1, 8'd1, 8'd2};
        automatic int e = 0;
        automatic int waited = 0;

        for (int i = 0; i < 26; i++) begin
            if (i == 5) begin
                vecs[i] = '{valid: 1'b0, data: 8'hee, last: 1'b0, exp_ready: 1'b1, exp_start: 1'b0};
            end else begin
                vecs[i] = '{valid: 1'b1, data: tmat[e], last: (e == 24),
                            exp_ready: (e != 24), exp_start: (e == 24)};
                e++;
            end
        end

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        det_done = 1'b0; det_resultado = 16'd6; res_ready = 1'b0;
        tick(); tick();
        check_reset("reset");
        rst = 1'b0;

        $display("[TB] early in_last on 10th element");
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(k);
            in_last  = (k == 9);
            tick();
            if (k < 9) mdl[k] = 8'h40 + 8'(k);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_output("early err_pulse", 200'(err_pulse), 200'(1'b1));
        check_output("early err_code",  200'(err_code),  200'(2'b01));
        check_output("early det_start", 200'(det_start), 200'(1'b0));
        check_output("early mat_flat",  mat_flat,        model_flat());
        tick();
        check_output("early pulse width", 200'(err_pulse), 200'(1'b0));
        check_output("early code held",   200'(err_code),  200'(2'b01));

        $display("[TB] table-driven test matrix frame");
        e = 0;
        for (int i = 0; i < 26; i++) begin
            apply_stimulus(vecs[i]);
            if (vecs[i].valid) begin
                mdl[e] = vecs[i].data;
                e++;
            end
            check_output($sformatf("vec%0d in_ready", i),  200'(in_ready),  200'(vecs[i].exp_ready));
            check_output($sformatf("vec%0d det_start", i), 200'(det_start), 200'(vecs[i].exp_start));
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_output("matrix mat_flat", mat_flat, model_flat());
        tick();
        check_output("wait det_start single", 200'(det_start), 200'(1'b0));
        check_output("wait busy",             200'(busy),      200'(1'b1));
        check_output("wait in_ready",         200'(in_ready),  200'(1'b0));
        det_done = 1'b1;
        tick();
        check_output("capture res_valid", 200'(res_valid), 200'(1'b1));
        check_output("capture res_data",  200'(res_data),  200'(16'd6));

        $display("[TB] host stalls for 20 cycles");
        for (int c = 0; c < 20; c++) begin
            tick();
            check_output("stall res_valid", 200'(res_valid), 200'(1'b1));
            check_output("stall res_data",  200'(res_data),  200'(16'd6));
            check_output("stall in_ready",  200'(in_ready),  200'(1'b0));
            check_output("stall mat_flat",  mat_flat,        model_flat());
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_output("release res_valid", 200'(res_valid), 200'(1'b0));
        check_output("release in_ready",  200'(in_ready),  200'(1'b1));

        $display("[TB] stale level-high done");
        send_frame(8'hf4);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_output("stale res_valid", 200'(res_valid), 200'(1'b0));
            check_output("stale busy",      200'(busy),      200'(1'b1));
        end
        det_done = 1'b0;
        tick();
        det_resultado = 16'hfffd;
        det_done = 1'b1;
        tick();
        check_output("fresh res_valid", 200'(res_valid), 200'(1'b1));
        check_output("fresh res_data",  200'(res_data),  200'(16'hfffd));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        det_done  = 1'b0;
        check_output("fresh accepted", 200'(res_valid), 200'(1'b0));

        $display("[TB] done never raised");
        send_frame(8'h05);
`ifdef DET_TIMEOUT_EN
        waited = 0;
        while (!res_valid && waited < 200) begin
            tick();
            waited++;
        end
        check_output("timeout latency",   200'(waited),    200'(65));
        check_output("timeout res_data",  200'(res_data),  200'(16'h8000));
        check_output("timeout err_code",  200'(err_code),  200'(2'b10));
        check_output("timeout err_pulse", 200'(err_pulse), 200'(1'b1));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        send_frame(8'h07);
        tick();
`else
        repeat (1000) tick();
        waited = 1000;
        check_output("no timeout res_valid", 200'(res_valid), 200'(1'b0));
        check_output("no timeout busy",      200'(busy),      200'(1'b1));
        check_output("no timeout err_code",  200'(err_code),  200'(2'b01));
`endif

        $display("[TB] reset while in WAIT");
        rst = 1'b1;
        tick();
        check_reset("rst wait");
        rst = 1'b0;

        $display("[TB] reset mid-LOAD at idx 12");
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(k);
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset("rst load");
        rst = 1'b0;
        tick();
        check_output("post rst det_start", 200'(det_start), 200'(1'b0));
        send_frame(8'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
